// File: rtl/mc_cpu_pkg.sv
// Shared definitions for the mc_cpu multi-cycle core: opcodes, instruction
// field positions and the controller state encoding.
package mc_cpu_pkg;

    localparam int W = 16;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_IMM  = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_BEZ  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int FA_HI  = 11;
    localparam int FA_LO  = 8;
    localparam int FB_HI  = 7;
    localparam int FB_LO  = 4;
    localparam int FC_HI  = 3;
    localparam int FC_LO  = 0;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } state_t;

    function automatic logic [W-1:0] sext8(input logic [7:0] v);
        return {{(W-8){v[7]}}, v};
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// 16 x 16-bit register file: two combinational read ports, one clocked
// write port, asynchronously cleared.
module mc_regfile
    import mc_cpu_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [3:0]   i_rd0_addr,
    input  logic [3:0]   i_rd1_addr,
    output logic [W-1:0] o_rd0_data,
    output logic [W-1:0] o_rd1_data,
    input  logic         i_we,
    input  logic [3:0]   i_wr_addr,
    input  logic [W-1:0] i_wr_data
);

    logic [W-1:0] r_regs [16];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd0_data = r_regs[i_rd0_addr];
    assign o_rd1_data = r_regs[i_rd1_addr];

endmodule

// File: rtl/mc_cpu.sv
// Multi-cycle 16-bit core: FETCH/EXEC/MEM sequencing, PC/IR, ALU and the
// shared data-bus tristate.
//   state | meaning
//   FETCH | IA=PC, IR captures ID at the closing edge
//   EXEC  | ALU/IMM writeback, PC update, LD/ST address (and ST data) capture
//   MEM   | LD: R[A]<-DD ; ST: core drives DD with RW=0
//   HALT  | terminal until reset
module mc_cpu
    import mc_cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic         CK,
    input  logic         RST,
    output logic [15:0]  IA,
    input  logic [15:0]  ID,
    output logic [15:0]  DA,
    inout  wire  [15:0]  DD,
    output logic         RW,
    output logic         HALTED
);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [W-1:0] r_pc;
    logic [W-1:0] r_ir;
    logic [W-1:0] r_ia;
    logic [W-1:0] r_da;
    logic [W-1:0] r_st_data;
    logic         r_rw;

    logic [3:0]   w_opc;
    logic [3:0]   w_fa;
    logic [3:0]   w_fb;
    logic [3:0]   w_fc;
    logic [7:0]   w_imm;
    logic [3:0]   w_rd0_addr;
    logic [3:0]   w_rd1_addr;
    logic [W-1:0] w_rd0;
    logic [W-1:0] w_rd1;
    logic [W-1:0] w_alu;
    logic         w_alu_we;
    logic [W-1:0] w_pc_inc;
    logic [W-1:0] w_pc_nxt;
    logic         w_rf_we;
    logic [W-1:0] w_rf_wd;

    assign w_opc = r_ir[OPC_HI:OPC_LO];
    assign w_fa  = r_ir[FA_HI:FA_LO];
    assign w_fb  = r_ir[FB_HI:FB_LO];
    assign w_fc  = r_ir[FC_HI:FC_LO];
    assign w_imm = r_ir[IMM_HI:IMM_LO];

    // Port 0 carries the address/test operand (A for ST/BEZ, B otherwise);
    // port 1 carries C for the ALU and the store data B for ST.
    assign w_rd0_addr = (w_opc == OP_ST || w_opc == OP_BEZ) ? w_fa : w_fb;
    assign w_rd1_addr = (w_opc == OP_ST) ? w_fb : w_fc;

    assign w_rf_we = ((r_state == EXEC) && w_alu_we) ||
                     ((r_state == MEM) && (w_opc == OP_LD));
    assign w_rf_wd = (r_state == MEM) ? DD : w_alu;

    mc_regfile u_regfile (
        .i_clk      (CK),
        .i_rst      (RST),
        .i_rd0_addr (w_rd0_addr),
        .i_rd1_addr (w_rd1_addr),
        .o_rd0_data (w_rd0),
        .o_rd1_data (w_rd1),
        .i_we       (w_rf_we),
        .i_wr_addr  (w_fa),
        .i_wr_data  (w_rf_wd)
    );

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FETCH:   w_state_nxt = EXEC;
            EXEC: begin
                if (w_opc == OP_LD || w_opc == OP_ST) begin
                    w_state_nxt = MEM;
                end else if (w_opc == OP_HALT) begin
                    w_state_nxt = HALT;
                end else begin
                    w_state_nxt = FETCH;
                end
            end
            MEM:     w_state_nxt = FETCH;
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = FETCH;
        endcase
    end

    assign w_pc_inc = r_pc + 16'd1;

    always_comb begin
        w_alu    = '0;
        w_alu_we = 1'b0;
        w_pc_nxt = w_pc_inc;
        case (w_opc)
            OP_ADD: begin w_alu = w_rd0 + w_rd1; w_alu_we = 1'b1; end
            OP_SUB: begin w_alu = w_rd0 - w_rd1; w_alu_we = 1'b1; end
            OP_AND: begin w_alu = w_rd0 & w_rd1; w_alu_we = 1'b1; end
            OP_OR:  begin w_alu = w_rd0 | w_rd1; w_alu_we = 1'b1; end
            OP_XOR: begin w_alu = w_rd0 ^ w_rd1; w_alu_we = 1'b1; end
            OP_IMM: begin w_alu = {8'h00, w_imm}; w_alu_we = 1'b1; end
            OP_JMP: w_pc_nxt = w_rd0;
            OP_BEZ: begin
                if (w_rd0 == '0) begin
                    w_pc_nxt = w_pc_inc + sext8(w_imm);
                end
            end
            OP_HALT: w_pc_nxt = r_pc;
            default: ;
        endcase
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_pc      <= RESET_PC;
            r_ia      <= RESET_PC;
            r_ir      <= '0;
            r_da      <= '0;
            r_rw      <= 1'b1;
            r_st_data <= '0;
        end else begin
            case (r_state)
                FETCH: r_ir <= ID;
                EXEC: begin
                    r_pc <= w_pc_nxt;
                    r_ia <= w_pc_nxt;
                    if (w_opc == OP_LD) begin
                        r_da <= w_rd0;
                    end else if (w_opc == OP_ST) begin
                        r_da      <= w_rd0;
                        r_st_data <= w_rd1;
                        r_rw      <= 1'b0;
                    end
                end
                MEM:     r_rw <= 1'b1;
                default: ;
            endcase
        end
    end

    assign DD     = r_rw ? {W{1'bz}} : r_st_data;
    assign IA     = r_ia;
    assign DA     = r_da;
    assign RW     = r_rw;
    assign HALTED = (r_state == HALT);

endmodule

// File: doc/mc_cpu.md
# mc_cpu

Multi-cycle 16-bit CPU core that sits between the instruction memory and the data memory in the `simcpu` system. It fetches one instruction per `FETCH` cycle over `IA`/`ID`, executes it, and performs loads and stores over the shared bidirectional `DD` bus under `RW` control. Both memories are modelled externally and update on the falling clock edge. The core only ever acts on the rising edge.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `CK`  in  1: clock; all state changes on rising edge.
- `RST`  in  1: reset, asynchronous, active-high.
- `IA`  out  16: instruction address (registered, equals PC during `FETCH`).
- `ID`  in  16: instruction word; valid by the next rising edge after `IA` changes.
- `DA`  out  16: data address (registered).
- `DD`  inout  16: data bus. Core drives it only when `RW`=0, otherwise high-Z.
- `RW`  out  1: 1 = read (default), 0 = write for exactly one cycle.
- `HALTED`  out  1: high once a HALT instruction has executed.

## Operation
- Instruction format: [15:12] opcode, [11:8] field A, [7:4] field B, [3:0] field C. Register file has 16 registers × 16 bits.
- Opcodes:
  - 0000 ADD: R[A]=R[B]+R[C].
  - 0001 SUB: R[A]=R[B]−R[C].
  - 0010 AND, 0011 OR, 0100 XOR: same operands as ADD.
  - 1000 LD: R[A]=M[R[B]].
  - 1010 ST: M[R[A]]=R[B].
  - 1100 IMM: R[A]={8'h00,[7:0]}.
  - 1101 JMP: PC=R[B].
  - 1110 BEZ: if R[A]==0 then PC=PC+1+sext([7:0]).
  - 1111 HALT.
  - Any other opcode is a NOP.
- Arithmetic is modulo 2^16 with no flags. PC increment wraps FFFF→0000.
- State machine:
  - FETCH → EXEC.
  - EXEC → MEM for LD/ST.
  - EXEC → HALT for HALT.
  - EXEC → FETCH for everything else.
  - MEM → FETCH.
  - HALT is terminal until reset.
- FETCH: `IA`=PC. At the closing edge, IR←ID.
- EXEC:
  - ALU ops and IMM write R[A] at the closing edge. PC←PC+1.
  - JMP and BEZ update PC as defined above.
  - LD/ST: DA←R[B] for LD, DA←R[A] for ST, registered at the closing edge. For ST, RW←0 at the same edge and the store data R[B] is latched.
- MEM:
  - LD: RW=1. R[A]←DD at the closing edge.
  - ST: RW=0 and DD=latched R[B] for the whole cycle. RW returns to 1 at the closing edge.
- Register writes where A equals B or C use the old operand values (read before write).
- Reset, asynchronous, at any point including mid-ST:
  - PC=RESET_PC, IA=RESET_PC, DA=0, RW=1, DD high-Z.
  - All registers cleared to 0. IR=0. HALTED=0. State=FETCH.

## Timing
- Latency: ALU/IMM/JMP/BEZ/NOP take 2 cycles. LD/ST take 3 cycles.
- Only one of `IA` or `DA`/`RW` is meaningful per cycle, so no structural hazard exists.
- `RW`=0 never lasts longer than one cycle. `DD` is high-Z in every cycle where `RW`=1.
- The first FETCH after reset release starts on the first rising edge where RST is low.
- The external memory write occurs on the falling edge inside the MEM cycle. Address and data are stable from the preceding rising edge.
- An LD result is usable by the very next instruction, since there is no forwarding requirement.

## Structure
- Package `mc_cpu_pkg`: opcode constants, the state enum {FETCH, EXEC, MEM, HALT}, and field bit ranges.
- Sub-module `mc_regfile`:
  - 16×16 registers.
  - Two asynchronous read ports and one synchronous write port.
  - Asynchronous clear on RST.
- The top level holds the FSM, PC, IR, the ALU case, and the `DD` tristate.

## Test plan
- Reset: hold RST for 100 units, then release. Required: IA=0, RW=1, DD=Z, and the first fetch of address 0 on the next rising edge.
- Program IMM R0,0; IMM R1,1; IMM R2,2; IMM R3,3; IMM R4,4; ADD R5,R1,R3; ST R5,R0. Required: DMEM[0]=4 written on the 15th cycle, and RW=0 only in that cycle.
- IMM R1,0x7F; ST to address 5; LD R6 from 5; ADD R7,R6,R6. Required: R7=0x00FE.
- Wrap cases:
  - IMM R1,0xFF, then repeated ADD R1,R1,R1 until wrap. Required: arithmetic wraps.
  - SUB R2,R0,R1 with R0=0 and R1=1. Required: R2=0xFFFF.
- Control flow:
  - BEZ with R[A]=0 and offset 0xFE. Required: loops back one instruction.
  - BEZ with R[A]≠0. Required: falls through.
  - HALT. Required: HALTED=1 and IA frozen.
- Assert RST during the MEM cycle of an ST. Required: RW=1 and DD=Z immediately, with no DMEM write afterward.
